// File: rtl/preparacao_pkg.sv
// Shared definitions for the preparacao response checker.
// Holds the golden truth tables of the block under test, the bit positions
// of its six outputs inside the response word, the checker state encoding
// and a helper that builds the expected response for an input vector.
package preparacao_pkg;

    // Golden functions indexed by m = {A,B,C,D}
    localparam logic [15:0] GOLD_F1 = 16'hD0C4;  // minterms 2,6,7,12,14,15
    localparam logic [15:0] GOLD_F2 = 16'hD011;  // minterms 0,4,12,14,15

    // Position of each output inside resp = {a,b,c,d,e,f}
    localparam int BIT_A = 5;
    localparam int BIT_B = 4;
    localparam int BIT_C = 3;
    localparam int BIT_D = 2;
    localparam int BIT_E = 1;
    localparam int BIT_F = 0;

    localparam int          N_VEC    = 16;
    localparam logic [3:0]  LAST_VEC = 4'(N_VEC - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRIVE = 3'd1,
        CHECK = 3'd2,
        TOUT  = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Expected six-bit response for input vector m
    function automatic logic [5:0] expected_resp(input logic [3:0] m);
        logic [5:0] r;
        r        = 6'b000000;
        r[BIT_A] = GOLD_F1[m];
        r[BIT_B] = GOLD_F1[m];
        r[BIT_C] = GOLD_F1[m];
        r[BIT_D] = GOLD_F2[m];
        r[BIT_E] = GOLD_F1[m];
        r[BIT_F] = GOLD_F2[m];
        return r;
    endfunction

endpackage

// File: rtl/preparacao_resp_cmp.sv
// Combinational comparator for one captured response.
// Ports:
//   vec      - input vector {A,B,C,D} the response belongs to
//   resp     - captured response {a,b,c,d,e,f}
//   fail     - 1 when any output bit differs from its golden value
//   mismatch - per-bit difference mask, same bit order as resp
module preparacao_resp_cmp
    import preparacao_pkg::*;
(
    input  logic [3:0] vec,
    input  logic [5:0] resp,
    output logic       fail,
    output logic [5:0] mismatch
);

    // Any mismatching bit fails the whole vector exactly once
    always_comb begin
        mismatch = resp ^ expected_resp(vec);
        fail     = |mismatch;
    end

endmodule

// File: rtl/preparacao_checker.sv
// Response analyzer for the exhaustive test of the preparacao block.
// Sweeps vec = 0..15 over a vec_valid/resp_valid handshake, checks each
// response against the golden tables and accumulates statistics.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   start             - one-cycle sweep start, honoured in IDLE/DONE only
//   vec, vec_valid    - vector driven to the block under test
//   resp, resp_valid  - response returned by the block under test
//   busy, done, pass  - sweep status; pass is meaningful while done is high
//   err_count         - failed vectors in the last sweep (0..16)
//   first_fail        - index of the first failed vector, 0 if none
//   timeout_seen      - at least one vector got no response in time
module preparacao_checker
    import preparacao_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [3:0] vec,
    output logic       vec_valid,
    input  logic [5:0] resp,
    input  logic       resp_valid,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_fail,
    output logic       timeout_seen
);

    localparam int unsigned       WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ZERO = WAIT_W'(0);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    state_e            state_r;
    state_e            state_next_s;
    logic [3:0]        vec_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [5:0]        resp_r;
    logic [4:0]        err_count_r;
    logic [4:0]        err_next_s;
    logic [3:0]        first_fail_r;
    logic              timeout_seen_r;
    logic              busy_r;
    logic              vec_valid_r;
    logic              done_r;
    logic              pass_r;
    logic              busy_next_s;
    logic              vec_valid_next_s;
    logic              done_next_s;
    logic              pass_next_s;
    logic              fail_s;
    logic              fail_event_s;
    // Per-bit mask is only looked at in waveforms
    logic [5:0]        mismatch_dbg_unused_s;

    preparacao_resp_cmp u_cmp (
        .vec      (vec_r),
        .resp     (resp_r),
        .fail     (fail_s),
        .mismatch (mismatch_dbg_unused_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a response wins over a timeout on the same edge
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_next_s = DRIVE;
                end else begin
                    state_next_s = state_r;
                end
            end
            DRIVE: begin
                if (resp_valid) begin
                    state_next_s = CHECK;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_next_s = TOUT;
                end else begin
                    state_next_s = DRIVE;
                end
            end
            CHECK, TOUT: begin
                if (vec_r == LAST_VEC) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = DRIVE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Failure accounting for the vector being retired this cycle
    always_comb begin
        fail_event_s = ((state_r == CHECK) && fail_s) || (state_r == TOUT);
        if (fail_event_s) begin
            err_next_s = err_count_r + 5'd1;
        end else begin
            err_next_s = err_count_r;
        end
    end

    // Output decode from the next state so the status flags come out of flops
    always_comb begin
        busy_next_s      = 1'b0;
        vec_valid_next_s = 1'b0;
        done_next_s      = 1'b0;
        pass_next_s      = 1'b0;
        case (state_next_s)
            DRIVE: begin
                busy_next_s      = 1'b1;
                vec_valid_next_s = 1'b1;
            end
            CHECK, TOUT: begin
                busy_next_s = 1'b1;
            end
            DONE: begin
                done_next_s = 1'b1;
                pass_next_s = (err_next_s == 5'd0);
            end
            default: begin
                busy_next_s = 1'b0;
            end
        endcase
    end

    // Output flops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r      <= 1'b0;
            vec_valid_r <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
        end else begin
            busy_r      <= busy_next_s;
            vec_valid_r <= vec_valid_next_s;
            done_r      <= done_next_s;
            pass_r      <= pass_next_s;
        end
    end

    // Vector counter, wait counter, response capture and sweep statistics
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_r          <= 4'd0;
            wait_cnt_r     <= WAIT_ZERO;
            resp_r         <= 6'd0;
            err_count_r    <= 5'd0;
            first_fail_r   <= 4'd0;
            timeout_seen_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        vec_r          <= 4'd0;
                        wait_cnt_r     <= WAIT_ZERO;
                        err_count_r    <= 5'd0;
                        first_fail_r   <= 4'd0;
                        timeout_seen_r <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (resp_valid) begin
                        resp_r     <= resp;
                        wait_cnt_r <= WAIT_ZERO;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_ONE;
                    end
                end
                CHECK, TOUT: begin
                    err_count_r <= err_next_s;
                    wait_cnt_r  <= WAIT_ZERO;
                    // Only the first failure of a sweep is recorded
                    if (fail_event_s && (err_count_r == 5'd0)) begin
                        first_fail_r <= vec_r;
                    end
                    if (state_r == TOUT) begin
                        timeout_seen_r <= 1'b1;
                    end
                    // Vector 15 is held so the final index stays visible in DONE
                    if (vec_r != LAST_VEC) begin
                        vec_r <= vec_r + 4'd1;
                    end
                end
                default: begin
                    vec_r <= vec_r;
                end
            endcase
        end
    end

    assign vec          = vec_r;
    assign vec_valid    = vec_valid_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign pass         = pass_r;
    assign err_count    = err_count_r;
    assign first_fail   = first_fail_r;
    assign timeout_seen = timeout_seen_r;

endmodule
